// File: rtl/ex_block.sv
// Execute stage: operand forwarding, immediate select, single-cycle ALU and a
// shift-add multiplier that stalls upstream for WIDTH cycles.
module ex_block #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [3:0]       op_dec,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] imm,
   input  logic             imm_sel,
   input  logic [1:0]       fwd_a_sel,
   input  logic [1:0]       fwd_b_sel,
   input  logic [WIDTH-1:0] ans_dm,
   input  logic             mem_en_in,
   input  logic             mem_rw_in,
   input  logic             mem_mux_sel_in,
   output logic [WIDTH-1:0] ans_ex,
   output logic [WIDTH-1:0] DM_data,
   output logic             mem_en_ex,
   output logic             mem_rw_ex,
   output logic             mem_mux_sel_dm,
   output logic             zero_ex,
   output logic             carry_ex,
   output logic             stall_ex
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] ans_q, ans_d, data_q, data_d;
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplr_q, mplr_d, ldata_q, ldata_d;
   logic             en_q, en_d, rw_q, rw_d, mux_q, mux_d;
   logic             len_q, len_d, lrw_q, lrw_d, lmux_q, lmux_d;
   logic             zero_q, zero_d, carry_q, carry_d, stall_q, stall_d;

   logic [WIDTH-1:0] opA, fB, opB, res, step_acc;
   logic [WIDTH:0]   sum;
   logic             cout;

   // Forwarding from ans_ex reads the register, never the ALU output.
   always_comb begin
      opA = (fwd_a_sel == 2'd1) ? ans_q : (fwd_a_sel == 2'd2) ? ans_dm : A;
      fB  = (fwd_b_sel == 2'd1) ? ans_q : (fwd_b_sel == 2'd2) ? ans_dm : B;
      opB = imm_sel ? imm : fB;
   end

   always_comb begin
      res  = '0;
      sum  = '0;
      cout = carry_q;
      case (op_dec)
         4'd0: begin
            sum  = {1'b0, opA} + {1'b0, opB};
            res  = sum[WIDTH-1:0];
            cout = sum[WIDTH];
         end
         4'd1: begin
            res  = opA - opB;
            cout = (opA < opB);
         end
         4'd2: res = opA & opB;
         4'd3: res = opA | opB;
         4'd4: res = opA ^ opB;
         4'd5: res = ~opA;
         4'd6: res = opA << opB[SHAMT_W-1:0];
         4'd7: res = $signed(opA) >>> opB[SHAMT_W-1:0];
         4'd9: res = opB;
         default: res = '0;
      endcase
   end

   assign step_acc = acc_q + (mplr_q[0] ? mcand_q : '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ans_d   = ans_q;
      data_d  = data_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      stall_d = stall_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      ldata_d = ldata_q;
      len_d   = len_q;
      lrw_d   = lrw_q;
      lmux_d  = lmux_q;
      en_d    = 1'b0;
      rw_d    = 1'b0;
      mux_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_in && op_dec == OP_MUL) begin
               mcand_d = opA;
               mplr_d  = opB;
               acc_d   = '0;
               cnt_d   = '0;
               ldata_d = fB;
               len_d   = mem_en_in;
               lrw_d   = mem_rw_in;
               lmux_d  = mem_mux_sel_in;
               stall_d = 1'b1;
               state_d = BUSY;
            end else if (valid_in) begin
               ans_d   = res;
               data_d  = fB;
               zero_d  = (res == '0);
               carry_d = cout;
               en_d    = mem_en_in;
               rw_d    = mem_rw_in;
               mux_d   = mem_mux_sel_in;
            end
         end
         BUSY: begin
            acc_d   = step_acc;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            // Last step: the product is step_acc, so it is written directly.
            if (cnt_q == CNT_LAST) begin
               ans_d   = step_acc;
               zero_d  = (step_acc == '0);
               data_d  = ldata_q;
               en_d    = len_q;
               rw_d    = lrw_q;
               mux_d   = lmux_q;
               stall_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ans_q   <= '0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         stall_q <= 1'b0;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         ldata_q <= '0;
         len_q   <= 1'b0;
         lrw_q   <= 1'b0;
         lmux_q  <= 1'b0;
         en_q    <= 1'b0;
         rw_q    <= 1'b0;
         mux_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ans_q   <= ans_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         stall_q <= stall_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         ldata_q <= ldata_d;
         len_q   <= len_d;
         lrw_q   <= lrw_d;
         lmux_q  <= lmux_d;
         en_q    <= en_d;
         rw_q    <= rw_d;
         mux_q   <= mux_d;
      end
   end

   assign ans_ex         = ans_q;
   assign DM_data        = data_q;
   assign mem_en_ex      = en_q;
   assign mem_rw_ex      = rw_q;
   assign mem_mux_sel_dm = mux_q;
   assign zero_ex        = zero_q;
   assign carry_ex       = carry_q;
   assign stall_ex       = stall_q;

endmodule

// File: tb/tb_ex_block.sv
// Randomised bench for ex_block against an arithmetic reference model.
module tb_ex_block;

   logic        clk = 1'b0;
   logic        reset, valid_in, imm_sel, mem_en_in, mem_rw_in, mem_mux_sel_in;
   logic [3:0]  op_dec;
   logic [15:0] A, B, imm, ans_dm;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [15:0] ans_ex, DM_data;
   logic        mem_en_ex, mem_rw_ex, mem_mux_sel_dm, zero_ex, carry_ex, stall_ex;

   int total = 0;
   int bad   = 0;

   // Reference state, as the DM stage would see it
   logic [15:0] m_ans, m_data;
   logic        m_zero, m_carry, m_en, m_rw, m_mux;

   always #5 clk = ~clk;

   ex_block dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .op_dec(op_dec),
      .A(A), .B(B), .imm(imm), .imm_sel(imm_sel),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ans_dm(ans_dm),
      .mem_en_in(mem_en_in), .mem_rw_in(mem_rw_in), .mem_mux_sel_in(mem_mux_sel_in),
      .ans_ex(ans_ex), .DM_data(DM_data), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
      .mem_mux_sel_dm(mem_mux_sel_dm), .zero_ex(zero_ex), .carry_ex(carry_ex),
      .stall_ex(stall_ex)
   );

   function automatic logic [15:0] m_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int unsigned ua, ub, sh;
      int sa;
      ua = a; ub = b; sh = b % 16; sa = $signed(a);
      case (op)
         4'd0: return 16'((ua + ub) % 65536);
         4'd1: return 16'((ua + 65536 - ub) % 65536);
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ~a;
         4'd6: return 16'((ua * (2 ** sh)) % 65536);
         4'd7: return 16'(sa >>> sh);
         4'd8: return 16'((longint'(ua) * longint'(ub)) % 65536);
         4'd9: return b;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] fwd(input logic [1:0] s, input logic [15:0] raw, input logic [15:0] dm);
      return (s == 2'd1) ? m_ans : (s == 2'd2) ? dm : raw;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one non-MUL slot (or bubble), clock it, and advance the model.
   task automatic run_op(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] im, input logic isel, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [15:0] adm, input logic en, input logic rw, input logic mux);
      logic [15:0] va, vb, ob, r;
      valid_in = v; op_dec = op; A = a; B = b; imm = im; imm_sel = isel;
      fwd_a_sel = fa; fwd_b_sel = fb; ans_dm = adm;
      mem_en_in = en; mem_rw_in = rw; mem_mux_sel_in = mux;
      va = fwd(fa, a, adm);
      vb = fwd(fb, b, adm);
      ob = isel ? im : vb;
      step();
      if (v) begin
         r = m_res(op, va, ob);
         if (op == 4'd0) m_carry = (int'(va) + int'(ob)) > 65535;
         if (op == 4'd1) m_carry = va < ob;
         m_ans = r; m_zero = (r == 16'h0); m_data = vb;
         m_en = en; m_rw = rw; m_mux = mux;
      end else begin
         m_en = 1'b0; m_rw = 1'b0; m_mux = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; valid_in = 1'b1; op_dec = 4'd0; A = 16'h1111; B = 16'h2222;
      imm = 16'h0; imm_sel = 1'b0; fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; ans_dm = 16'h0;
      mem_en_in = 1'b1; mem_rw_in = 1'b1; mem_mux_sel_in = 1'b1;
      step(); step();
      total++;
      if ({ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, zero_ex, carry_ex, stall_ex} !== 38'h0) begin
         bad++;
         $display("FAIL reset_outputs: ans=%h dm=%h en=%b rw=%b mux=%b z=%b c=%b st=%b, required all 0",
                  ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, zero_ex, carry_ex, stall_ex);
      end
      m_ans = 0; m_data = 0; m_zero = 0; m_carry = 0; m_en = 0; m_rw = 0; m_mux = 0;
      reset = 1'b1;
      run_op(1, 4'd0, 16'h7FFF, 16'h0001, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
      total++;
      if (ans_ex !== 16'h8000 || carry_ex !== 1'b0 || zero_ex !== 1'b0) begin
         bad++;
         $display("FAIL reset_add: ans=%h c=%b z=%b, required 8000 0 0", ans_ex, carry_ex, zero_ex);
      end
   endtask

   task automatic test_sub();
      run_op(1, 4'd1, 16'h0003, 16'h0005, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
      total++;
      if (ans_ex !== 16'hFFFE || carry_ex !== 1'b1) begin
         bad++;
         $display("FAIL sub_borrow: ans=%h c=%b, required fffe 1", ans_ex, carry_ex);
      end
      run_op(1, 4'd1, 16'h0004, 16'h0004, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
      total++;
      if (ans_ex !== 16'h0000 || zero_ex !== 1'b1 || carry_ex !== 1'b0) begin
         bad++;
         $display("FAIL sub_zero: ans=%h z=%b c=%b, required 0000 1 0", ans_ex, zero_ex, carry_ex);
      end
   endtask

   task automatic test_store();
      run_op(1, 4'd0, 16'h0003, 16'hFFFF, 16'h0000, 1, 0, 0, 16'h0, 1, 1, 1);
      total++;
      if (ans_ex !== 16'h0003 || DM_data !== 16'hFFFF || {mem_en_ex, mem_rw_ex, mem_mux_sel_dm} !== 3'b111) begin
         bad++;
         $display("FAIL store: ans=%h dm=%h ctl=%b%b%b, required 0003 ffff 111",
                  ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm);
      end
      run_op(0, 4'd0, 16'h5555, 16'h5555, 16'h0, 0, 0, 0, 16'h0, 1, 1, 1);
      total++;
      if (ans_ex !== 16'h0003 || DM_data !== 16'hFFFF || {mem_en_ex, mem_rw_ex, mem_mux_sel_dm} !== 3'b000) begin
         bad++;
         $display("FAIL bubble: ans=%h dm=%h ctl=%b%b%b, required 0003 ffff 000",
                  ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm);
      end
   endtask

   task automatic test_fwd();
      run_op(1, 4'd0, 16'h0F0F, 16'h0001, 16'h0, 0, 2'd2, 0, 16'h1234, 0, 0, 0);
      total++;
      if (ans_ex !== 16'h1235) begin
         bad++;
         $display("FAIL fwd_dm: ans=%h, required 1235", ans_ex);
      end
      run_op(1, 4'd0, 16'h0F0F, 16'h0001, 16'h0, 0, 2'd1, 0, 16'h9999, 0, 0, 0);
      total++;
      if (ans_ex !== 16'h1236) begin
         bad++;
         $display("FAIL fwd_ex: ans=%h, required 1236", ans_ex);
      end
   endtask

   // Full multiply: accept edge plus WIDTH busy edges with garbage inputs.
   task automatic mul_one(input logic [15:0] a, input logic [15:0] b, input logic [15:0] im, input logic isel,
                          input logic en, input logic rw, input logic mux);
      logic [15:0] prev_ans, ob, p;
      prev_ans = m_ans;
      ob = isel ? im : b;
      p = m_res(4'd8, a, ob);
      valid_in = 1; op_dec = 4'd8; A = a; B = b; imm = im; imm_sel = isel;
      fwd_a_sel = 0; fwd_b_sel = 0; mem_en_in = en; mem_rw_in = rw; mem_mux_sel_in = mux;
      step();
      for (int i = 0; i < 16; i++) begin
         total++;
         if (stall_ex !== 1'b1 || {mem_en_ex, mem_rw_ex, mem_mux_sel_dm} !== 3'b000 || ans_ex !== prev_ans) begin
            bad++;
            $display("FAIL mul_busy[%0d]: st=%b ctl=%b%b%b ans=%h, required 1 000 %h",
                     i, stall_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, ans_ex, prev_ans);
         end
         valid_in = 1'($urandom); op_dec = 4'($urandom); A = 16'($urandom); B = 16'($urandom);
         imm = 16'($urandom); imm_sel = 1'($urandom); fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
         ans_dm = 16'($urandom); mem_en_in = 1'($urandom); mem_rw_in = 1'($urandom); mem_mux_sel_in = 1'($urandom);
         step();
      end
      m_ans = p; m_zero = (p == 16'h0); m_data = b; m_en = en; m_rw = rw; m_mux = mux;
      valid_in = 0;
      total++;
      if (ans_ex !== m_ans || zero_ex !== m_zero || carry_ex !== m_carry || DM_data !== m_data ||
          {mem_en_ex, mem_rw_ex, mem_mux_sel_dm} !== {m_en, m_rw, m_mux} || stall_ex !== 1'b0) begin
         bad++;
         $display("FAIL mul_done %h*%h: ans=%h z=%b c=%b dm=%h ctl=%b%b%b st=%b, required %h %b %b %h %b%b%b 0",
                  a, ob, ans_ex, zero_ex, carry_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, stall_ex,
                  m_ans, m_zero, m_carry, m_data, m_en, m_rw, m_mux);
      end
   endtask

   task automatic test_mul();
      mul_one(16'h0012, 16'h0034, 16'h0, 0, 1, 1, 0);
      total++;
      if (ans_ex !== 16'h03A8) begin
         bad++;
         $display("FAIL mul_const: ans=%h, required 03a8", ans_ex);
      end
      run_op(1, 4'd0, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
      mul_one(16'hFFFF, 16'h0002, 16'h0, 0, 0, 0, 1);
      total++;
      if (ans_ex !== 16'hFFFE || carry_ex !== 1'b1) begin
         bad++;
         $display("FAIL mul_neg: ans=%h c=%b, required fffe 1", ans_ex, carry_ex);
      end
      mul_one(16'h0100, 16'h0100, 16'h0, 0, 1, 0, 1);
      total++;
      if (ans_ex !== 16'h0000 || zero_ex !== 1'b1) begin
         bad++;
         $display("FAIL mul_zero: ans=%h z=%b, required 0000 1", ans_ex, zero_ex);
      end
   endtask

   task automatic test_reset_mid_mul();
      valid_in = 1; op_dec = 4'd8; A = 16'h0033; B = 16'h0077; imm_sel = 0;
      fwd_a_sel = 0; fwd_b_sel = 0; mem_en_in = 1; mem_rw_in = 1; mem_mux_sel_in = 1;
      step();
      for (int i = 0; i < 7; i++) step();
      reset = 1'b0;
      step();
      total++;
      if ({ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, zero_ex, carry_ex, stall_ex} !== 38'h0) begin
         bad++;
         $display("FAIL reset_mid_mul: ans=%h dm=%h en=%b rw=%b mux=%b z=%b c=%b st=%b, required all 0",
                  ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, zero_ex, carry_ex, stall_ex);
      end
      m_ans = 0; m_data = 0; m_zero = 0; m_carry = 0; m_en = 0; m_rw = 0; m_mux = 0;
      reset = 1'b1;
      run_op(1, 4'd0, 16'h0001, 16'h0001, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0);
      total++;
      if (ans_ex !== 16'h0002 || stall_ex !== 1'b0) begin
         bad++;
         $display("FAIL after_abort: ans=%h st=%b, required 0002 0", ans_ex, stall_ex);
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      for (int n = 0; n < 200; n++) begin
         op = 4'($urandom);
         if (op == 4'd8 && ($urandom % 4) == 0) begin
            mul_one(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
         end else begin
            if (op == 4'd8) op = 4'd0;
            run_op(($urandom % 5) != 0, op, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                   2'($urandom), 2'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         end
         total++;
         if (ans_ex !== m_ans || DM_data !== m_data || zero_ex !== m_zero || carry_ex !== m_carry ||
             {mem_en_ex, mem_rw_ex, mem_mux_sel_dm} !== {m_en, m_rw, m_mux} || stall_ex !== 1'b0) begin
            bad++;
            $display("FAIL random[%0d] op=%0d: ans=%h dm=%h z=%b c=%b ctl=%b%b%b st=%b, required %h %h %b %b %b%b%b 0",
                     n, op, ans_ex, DM_data, zero_ex, carry_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_dm, stall_ex,
                     m_ans, m_data, m_zero, m_carry, m_en, m_rw, m_mux);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_store();
      test_fwd();
      test_mul();
      test_reset_mid_mul();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
